// File: rtl/alu_op_sequencer.sv
// Sequences a single-cycle AND/OR/ADD ALU to run AND, OR, ADD, SUB, SLT and shift-add MUL.
// Optional: define MUL_EARLY_EXIT_EN to end MUL once the remaining multiplier bits are zero.
module alu_op_sequencer #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MUL_ITERS = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_op_i,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [WIDTH-1:0] resp_result_o,
    output logic             resp_cout_o,
    output logic             resp_ovf_o,
    output logic             resp_zero_o,
    output logic             resp_err_o,
    output logic [WIDTH-1:0] alu_in1_o,
    output logic [WIDTH-1:0] alu_in2_o,
    output logic             alu_binvert_o,
    output logic             alu_cin_o,
    output logic [1:0]       alu_operation_o,
    input  logic [WIDTH-1:0] alu_result_i,
    input  logic             alu_cout_i
);
    localparam int unsigned IterW = $clog2(MUL_ITERS) + 1;
    localparam logic [2:0] OpAnd = 3'b000;
    localparam logic [2:0] OpOr  = 3'b001;
    localparam logic [2:0] OpAdd = 3'b010;
    localparam logic [2:0] OpSub = 3'b011;
    localparam logic [2:0] OpSlt = 3'b100;
    localparam logic [2:0] OpMul = 3'b101;

    typedef enum logic [1:0] {StIdle, StSingle, StExec, StResp} state_e;

    state_e           state_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
    logic [IterW-1:0] iter_q;

    logic [WIDTH-1:0] in2_eff, acc_d, mcand_d, mplier_d;
    logic             ovf, slt_bit, mul_done;

    always_comb begin
        in2_eff  = alu_binvert_o ? ~alu_in2_o : alu_in2_o;
        ovf      = (alu_in1_o[WIDTH-1] == in2_eff[WIDTH-1]) &&
                   (alu_result_i[WIDTH-1] != alu_in1_o[WIDTH-1]);
        slt_bit  = alu_result_i[WIDTH-1] ^ ovf;
        acc_d    = mplier_q[0] ? alu_result_i : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
`ifdef MUL_EARLY_EXIT_EN
        mul_done = (mplier_d == '0);
`else
        mul_done = (iter_q == IterW'(MUL_ITERS - 1));
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= StIdle;
            op_q            <= '0;
            acc_q           <= '0;
            mcand_q         <= '0;
            mplier_q        <= '0;
            iter_q          <= '0;
            req_ready_o     <= 1'b1;
            resp_valid_o    <= 1'b0;
            resp_result_o   <= '0;
            resp_cout_o     <= 1'b0;
            resp_ovf_o      <= 1'b0;
            resp_zero_o     <= 1'b0;
            resp_err_o      <= 1'b0;
            alu_in1_o       <= '0;
            alu_in2_o       <= '0;
            alu_binvert_o   <= 1'b0;
            alu_cin_o       <= 1'b0;
            alu_operation_o <= 2'b00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o <= 1'b0;
                        op_q        <= req_op_i;
                        state_q     <= StSingle;
                        case (req_op_i)
                            OpAnd, OpOr, OpAdd, OpSub, OpSlt: begin
                                alu_in1_o       <= req_a_i;
                                alu_in2_o       <= req_b_i;
                                alu_operation_o <= (req_op_i == OpAnd) ? 2'b00 :
                                                   (req_op_i == OpOr)  ? 2'b01 : 2'b10;
                                alu_binvert_o   <= (req_op_i == OpSub) || (req_op_i == OpSlt);
                                alu_cin_o       <= (req_op_i == OpSub) || (req_op_i == OpSlt);
                            end
                            OpMul: begin
                                alu_in1_o       <= '0;
                                alu_in2_o       <= req_a_i;
                                alu_operation_o <= 2'b10;
                                alu_binvert_o   <= 1'b0;
                                alu_cin_o       <= 1'b0;
                                acc_q           <= '0;
                                mcand_q         <= req_a_i;
                                mplier_q        <= req_b_i;
                                iter_q          <= '0;
                                state_q         <= StExec;
                            end
                            default: ; // illegal opcode leaves the ALU untouched
                        endcase
                    end
                end
                StSingle: begin
                    state_q      <= StResp;
                    resp_valid_o <= 1'b1;
                    resp_cout_o  <= 1'b0;
                    resp_ovf_o   <= 1'b0;
                    resp_err_o   <= 1'b0;
                    case (op_q)
                        OpAnd, OpOr: begin
                            resp_result_o <= alu_result_i;
                            resp_zero_o   <= (alu_result_i == '0);
                        end
                        OpAdd, OpSub: begin
                            resp_result_o <= alu_result_i;
                            resp_zero_o   <= (alu_result_i == '0);
                            resp_cout_o   <= alu_cout_i;
                            resp_ovf_o    <= ovf;
                        end
                        OpSlt: begin
                            resp_result_o <= {{(WIDTH-1){1'b0}}, slt_bit};
                            resp_zero_o   <= !slt_bit;
                        end
                        default: begin
                            resp_result_o <= '0;
                            resp_zero_o   <= 1'b1;
                            resp_err_o    <= 1'b1;
                        end
                    endcase
                end
                StExec: begin
                    // Next iteration's ALU operands follow the updated accumulator.
                    acc_q     <= acc_d;
                    mcand_q   <= mcand_d;
                    mplier_q  <= mplier_d;
                    iter_q    <= iter_q + 1'b1;
                    alu_in1_o <= acc_d;
                    alu_in2_o <= mcand_d;
                    if (mul_done) begin
                        state_q       <= StResp;
                        resp_valid_o  <= 1'b1;
                        resp_result_o <= acc_d;
                        resp_zero_o   <= (acc_d == '0);
                        resp_cout_o   <= 1'b0;
                        resp_ovf_o    <= 1'b0;
                        resp_err_o    <= 1'b0;
                    end
                end
                StResp: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        req_ready_o  <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU and arithmetic reference model.
module tb_alu_op_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, resp_valid, resp_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b, resp_result;
    logic        resp_cout, resp_ovf, resp_zero, resp_err;
    logic [31:0] alu_in1, alu_in2, alu_result, b_eff;
    logic        alu_binvert, alu_cin, alu_cout;
    logic [1:0]  alu_operation;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(32), .MUL_ITERS(32)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_a_i(req_a), .req_b_i(req_b),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_result_o(resp_result),
        .resp_cout_o(resp_cout), .resp_ovf_o(resp_ovf), .resp_zero_o(resp_zero),
        .resp_err_o(resp_err),
        .alu_in1_o(alu_in1), .alu_in2_o(alu_in2), .alu_binvert_o(alu_binvert),
        .alu_cin_o(alu_cin), .alu_operation_o(alu_operation),
        .alu_result_i(alu_result), .alu_cout_i(alu_cout)
    );

    // Team ALU: combinational AND/OR/ADD with B-invert and carry-in.
    assign b_eff = alu_binvert ? ~alu_in2 : alu_in2;
    always_comb begin
        alu_cout   = 1'b0;
        alu_result = '0;
        case (alu_operation)
            2'b00:   alu_result = alu_in1 & b_eff;
            2'b01:   alu_result = alu_in1 | b_eff;
            default: {alu_cout, alu_result} = {1'b0, alu_in1} + {1'b0, b_eff} + 33'(alu_cin);
        endcase
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, res;
        logic        cout, ovf, err;
    } vec_t;
    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, b,
                                   output logic [31:0] res, output logic cout, ovf, err);
        longint sa, sb, full;
        logic [63:0] prod;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = '0; cout = 1'b0; ovf = 1'b0; err = 1'b0;
        case (op)
            3'd0: res = a & b;
            3'd1: res = a | b;
            3'd2: begin
                {cout, res} = {1'b0, a} + {1'b0, b};
                full = sa + sb;
                ovf = (full != longint'($signed(res)));
            end
            3'd3: begin
                res = a - b;
                cout = (a >= b);
                full = sa - sb;
                ovf = (full != longint'($signed(res)));
            end
            3'd4: res = (sa < sb) ? 32'd1 : 32'd0;
            3'd5: begin
                prod = {32'b0, a} * {32'b0, b};
                res = prod[31:0];
            end
            default: err = 1'b1;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] b);
        if (op != 3'd5) return 2;
`ifdef MUL_EARLY_EXIT_EN
        for (int i = 31; i >= 0; i--) if (b[i]) return i + 2;
        return 2;
`else
        return 33;
`endif
    endfunction

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, b,
                          input logic [31:0] res, input logic cout, ovf, err,
                          input int hold, input bit intrude);
        int lat;
        @(negedge clk);
        chk({name, " req_ready idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'(exp_lat(op, b)));
        chk({name, " result"}, resp_result, res);
        chk({name, " cout"}, 32'(resp_cout), 32'(cout));
        chk({name, " ovf"}, 32'(resp_ovf), 32'(ovf));
        chk({name, " zero"}, 32'(resp_zero), 32'(res == 32'd0));
        chk({name, " err"}, 32'(resp_err), 32'(err));
        if (intrude) begin
            req_valid = 1'b1; req_op = 3'd1; req_a = 32'h1; req_b = 32'h2;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, " held result"}, resp_result, res);
            chk({name, " held valid"}, 32'(resp_valid), 32'd1);
            chk({name, " held req_ready"}, 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({name, " resp done"}, 32'(resp_valid), 32'd0);
        chk({name, " ready after"}, 32'(req_ready), 32'd1);
        if (intrude) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk({name, " no phantom op"}, 32'(resp_valid), 32'd0);
            end
        end
    endtask

    initial begin
        logic [31:0] r, a, b;
        logic [2:0]  op;
        logic        c, o, e;
        int          seen;

        vecs[0]  = '{3'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{3'd3, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{3'd4, 32'hFFFFFFFE, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'd5, 32'h00001234, 32'h00000100, 32'h00123400, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'd1, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'd3, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'd4, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'd2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{3'd7, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{3'd5, 32'h00000077, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset resp flags", {28'd0, resp_cout, resp_ovf, resp_zero, resp_err}, 32'd0);
        chk("reset alu_in1", alu_in1, 32'd0);
        rst_n = 1'b1;

        // Illegal opcode first: the ALU ports must still hold their reset values.
        run_op("illegal110", 3'b110, 32'hDEADBEEF, 32'h0BADF00D, 32'd0, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        chk("illegal alu_in1", alu_in1, 32'd0);
        chk("illegal alu_in2", alu_in2, 32'd0);
        chk("illegal alu ctrl", {27'd0, alu_binvert, alu_cin, 1'b0, alu_operation}, 32'd0);
        run_op("or after illegal", 3'd1, 32'h0F000000, 32'h000000F0, 32'h0F0000F0,
               1'b0, 1'b0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 11; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                   vecs[i].cout, vecs[i].ovf, vecs[i].err, i % 3, 1'b0);

        run_op("and hold", 3'd0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0,
               1'b0, 1'b0, 1'b0, 5, 1'b1);

        // Reset in the middle of a MUL: everything returns to reset values at once.
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd5; req_a = 32'h00001234; req_b = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid mul alu_in2 busy", 32'(alu_in2 != 32'd0), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort req_ready", 32'(req_ready), 32'd1);
        chk("abort resp_valid", 32'(resp_valid), 32'd0);
        chk("abort alu_in1", alu_in1, 32'd0);
        chk("abort alu_in2", alu_in2, 32'd0);
        chk("abort alu ctrl", {27'd0, alu_binvert, alu_cin, 1'b0, alu_operation}, 32'd0);
        chk("abort resp_result", resp_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("no resp after abort", 32'(seen), 32'd0);
        run_op("add 3+4", 3'd2, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if (n % 4 == 1) b = b & 32'h000003FF;
            if (n % 8 == 3) a = 32'h80000000;
            ref_op(op, a, b, r, c, o, e);
            run_op($sformatf("rand%0d op%0d", n, op), op, a, b, r, c, o, e,
                   int'($urandom_range(0, 3)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
